// File: rtl/niu_iter_alu.sv
// niu_iter_alu: Niu32 execution unit with start/done handshake, iterative MLT/DIV.
// Optional macro NIU_ALU_FAST_MUL_EN makes MLT single-cycle. Rev 1.0
`default_nettype none

module niu_iter_alu #(
  parameter int WORD_SIZE  = 32,
  parameter int OP_BITS    = 5,
  parameter int SHAMT_BITS = $clog2(WORD_SIZE)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [OP_BITS-1:0]   func,
  input  logic [WORD_SIZE-1:0] a_in,
  input  logic [WORD_SIZE-1:0] b_in,
  output logic                 busy,
  output logic                 done,
  output logic [WORD_SIZE-1:0] result,
  output logic                 div_zero,
  output logic                 illegal
);

  localparam int                   c_CW        = $clog2(WORD_SIZE) + 1;
  localparam logic [c_CW-1:0]      c_LAST      = c_CW'(WORD_SIZE - 1);
  localparam logic [WORD_SIZE-1:0] c_NBYTES    = WORD_SIZE'(WORD_SIZE / 8);
  localparam logic [WORD_SIZE-1:0] c_BYTE_MASK = WORD_SIZE'(8'hFF);
  localparam logic [WORD_SIZE-1:0] c_ONE       = WORD_SIZE'(1);

  localparam logic [OP_BITS-1:0] c_F_SUB  = OP_BITS'(5'b00000);
  localparam logic [OP_BITS-1:0] c_F_ADD  = OP_BITS'(5'b00001);
  localparam logic [OP_BITS-1:0] c_F_MLT  = OP_BITS'(5'b00010);
  localparam logic [OP_BITS-1:0] c_F_DIV  = OP_BITS'(5'b00011);
  localparam logic [OP_BITS-1:0] c_F_NOT  = OP_BITS'(5'b00100);
  localparam logic [OP_BITS-1:0] c_F_AND  = OP_BITS'(5'b00101);
  localparam logic [OP_BITS-1:0] c_F_OR   = OP_BITS'(5'b00110);
  localparam logic [OP_BITS-1:0] c_F_XOR  = OP_BITS'(5'b00111);
  localparam logic [OP_BITS-1:0] c_F_SUL  = OP_BITS'(5'b01000);
  localparam logic [OP_BITS-1:0] c_F_SSL  = OP_BITS'(5'b01001);
  localparam logic [OP_BITS-1:0] c_F_SUR  = OP_BITS'(5'b01010);
  localparam logic [OP_BITS-1:0] c_F_SSR  = OP_BITS'(5'b01011);
  localparam logic [OP_BITS-1:0] c_F_EQ   = OP_BITS'(5'b10000);
  localparam logic [OP_BITS-1:0] c_F_NEQ  = OP_BITS'(5'b10001);
  localparam logic [OP_BITS-1:0] c_F_LT   = OP_BITS'(5'b10010);
  localparam logic [OP_BITS-1:0] c_F_LEQ  = OP_BITS'(5'b10011);
  localparam logic [OP_BITS-1:0] c_F_BSEL = OP_BITS'(5'b11101);
  localparam logic [OP_BITS-1:0] c_F_BCLR = OP_BITS'(5'b11110);

`ifdef NIU_ALU_FAST_MUL_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_DIV = 2'd2} state_t;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_MUL = 2'd1, S_DIV = 2'd2} state_t;
`endif

  state_t                 r_state, w_state_nx;
  logic [c_CW-1:0]        r_cnt;
  logic [WORD_SIZE-1:0]   r_x, r_y, r_acc;
  logic                   r_neg;
  logic [WORD_SIZE-1:0]   r_result;
  logic                   r_done, r_div_zero, r_illegal;

  logic [WORD_SIZE-1:0]   w_res, w_k, w_bsh, w_abs_a, w_abs_b;
  logic                   w_ill, w_dz, w_last;
  logic [SHAMT_BITS-1:0]  w_shamt;
  logic [WORD_SIZE-1:0]   w_x_nx, w_y_nx, w_acc_nx, w_fin_mag, w_fin;
  logic [WORD_SIZE:0]     w_rem_sh, w_diff;

  assign w_shamt = b_in[SHAMT_BITS-1:0];
  assign w_abs_a = a_in[WORD_SIZE-1] ? (~a_in + c_ONE) : a_in;
  assign w_abs_b = b_in[WORD_SIZE-1] ? (~b_in + c_ONE) : b_in;
  assign w_last  = (r_cnt == c_LAST);

  // Single-cycle result path; byte 0 is the most significant byte.
  always_comb begin
    w_res = '0;
    w_ill = 1'b0;
    w_dz  = 1'b0;
    w_k   = b_in % c_NBYTES;
    w_bsh = (c_NBYTES - c_ONE - w_k) << 3;
    case (func)
      c_F_SUB:  w_res = a_in - b_in;
      c_F_ADD:  w_res = a_in + b_in;
`ifdef NIU_ALU_FAST_MUL_EN
      c_F_MLT:  w_res = a_in * b_in;
`else
      c_F_MLT:  w_res = '0;
`endif
      c_F_DIV:  begin w_res = '1; w_dz = 1'b1; end
      c_F_NOT:  w_res = ~a_in;
      c_F_AND:  w_res = a_in & b_in;
      c_F_OR:   w_res = a_in | b_in;
      c_F_XOR:  w_res = a_in ^ b_in;
      c_F_SUL,
      c_F_SSL:  w_res = a_in << w_shamt;
      c_F_SUR:  w_res = a_in >> w_shamt;
      c_F_SSR:  w_res = $signed(a_in) >>> w_shamt;
      c_F_EQ:   w_res = {{(WORD_SIZE-1){1'b0}}, (a_in == b_in)};
      c_F_NEQ:  w_res = {{(WORD_SIZE-1){1'b0}}, (a_in != b_in)};
      c_F_LT:   w_res = {{(WORD_SIZE-1){1'b0}}, ($signed(a_in) <  $signed(b_in))};
      c_F_LEQ:  w_res = {{(WORD_SIZE-1){1'b0}}, ($signed(a_in) <= $signed(b_in))};
      c_F_BSEL: w_res = (a_in >> w_bsh) & c_BYTE_MASK;
      c_F_BCLR: w_res = a_in & ~(c_BYTE_MASK << w_bsh);
      default:  w_ill = 1'b1;
    endcase
  end

  // One iteration step: x=multiplicand/divisor, y=multiplier/quotient, acc=product/remainder.
  always_comb begin
    w_x_nx   = r_x;
    w_y_nx   = r_y;
    w_acc_nx = r_acc;
    w_rem_sh = {r_acc, r_y[WORD_SIZE-1]};
    w_diff   = w_rem_sh - {1'b0, r_x};
    case (r_state)
`ifndef NIU_ALU_FAST_MUL_EN
      S_MUL: begin
        w_acc_nx = r_y[0] ? (r_acc + r_x) : r_acc;
        w_x_nx   = r_x << 1;
        w_y_nx   = r_y >> 1;
      end
`endif
      S_DIV: begin
        w_acc_nx = w_diff[WORD_SIZE] ? w_rem_sh[WORD_SIZE-1:0] : w_diff[WORD_SIZE-1:0];
        w_y_nx   = {r_y[WORD_SIZE-2:0], ~w_diff[WORD_SIZE]};
      end
      default: ;
    endcase
    w_fin_mag = (r_state == S_DIV) ? w_y_nx : w_acc_nx;
    w_fin     = r_neg ? (~w_fin_mag + c_ONE) : w_fin_mag;
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
`ifndef NIU_ALU_FAST_MUL_EN
          if (func == c_F_MLT) w_state_nx = S_MUL;
`endif
          if (func == c_F_DIV && b_in != '0) w_state_nx = S_DIV;
        end
      end
      default: if (w_last) w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nx;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt      <= '0;
      r_x        <= '0;
      r_y        <= '0;
      r_acc      <= '0;
      r_neg      <= 1'b0;
      r_result   <= '0;
      r_done     <= 1'b0;
      r_div_zero <= 1'b0;
      r_illegal  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_state == S_IDLE) begin
        if (start) begin
          r_cnt <= '0;
          r_acc <= '0;
          r_neg <= a_in[WORD_SIZE-1] ^ b_in[WORD_SIZE-1];
          if (w_state_nx == S_DIV) begin
            r_x <= w_abs_b;
            r_y <= w_abs_a;
          end else begin
            r_x <= w_abs_a;
            r_y <= w_abs_b;
          end
          if (w_state_nx == S_IDLE) begin
            r_result   <= w_res;
            r_div_zero <= w_dz;
            r_illegal  <= w_ill;
            r_done     <= 1'b1;
          end
        end
      end else begin
        r_x   <= w_x_nx;
        r_y   <= w_y_nx;
        r_acc <= w_acc_nx;
        r_cnt <= r_cnt + c_CW'(1);
        if (w_last) begin
          r_cnt      <= '0;
          r_result   <= w_fin;
          r_div_zero <= 1'b0;
          r_illegal  <= 1'b0;
          r_done     <= 1'b1;
        end
      end
    end
  end

  assign busy     = (r_state != S_IDLE);
  assign done     = r_done;
  assign result   = r_result;
  assign div_zero = r_div_zero;
  assign illegal  = r_illegal;

endmodule

`default_nettype wire

// File: doc/niu_iter_alu.md
Name: niu_iter_alu

Overview:
- Parametrised multicycle execution unit for the Niu32 datapath.
- Replaces the free-running bus-coupled ALU with a start/done handshake block.
- Supports generic WORD_SIZE, iterative signed multiply and divide, divide-by-zero and illegal-function flags, and generalised byte select/clear.
- Sits between the A/B operand registers and the bus driver; the control FSM waits on done before driving the result.

Parameters:
WORD_SIZE, 32, operand/result width in bits; a multiple of 8 and at least 16
OP_BITS, 5, function code width
SHAMT_BITS, $clog2(WORD_SIZE), bits of b_in used as shift amount

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-low reset (asserted when 0)
start  in  1  request; sampled only when busy=0
func  in  OP_BITS  operation code (Niu32 secondary opcode encoding)
a_in  in  WORD_SIZE  operand A, signed
b_in  in  WORD_SIZE  operand B, signed
busy  out  1  iterative operation in progress
done  out  1  one-cycle pulse: result and flags valid
result  out  WORD_SIZE  registered result; held until next done
div_zero  out  1  last completed op was DIV with b=0
illegal  out  1  last completed op had an unsupported func

Behaviour:
- Reset (reset=0): state IDLE, busy=0, done=0, result=0, div_zero=0, illegal=0, iteration counter=0. Takes effect immediately; any in-flight operation is aborted and discarded.
- Operands and func are latched at the accepting edge. Later changes to the inputs have no effect on an operation in progress.
- Accept rule: start=1 and busy=0 at a rising edge E0. start while busy=1 is ignored, not queued. start in the same cycle as done is accepted.
- FSM states: IDLE, MUL, DIV.
  - IDLE --start & (func=MLT)--> MUL.
  - IDLE --start & (func=DIV) & b≠0--> DIV.
  - Every other accepted func completes in IDLE.
  - MUL/DIV --counter reaches WORD_SIZE--> IDLE.
- Single-cycle ops: result, flags and done=1 are registered at E0. done stays high for one cycle only. busy stays 0.
- Iterative ops:
  - busy=1 from E0.
  - One iteration per edge.
  - result and flags registered at edge E0+WORD_SIZE; done=1 for the following cycle; busy falls on the same edge.
- Function codes:
  - SUB=00000, ADD=00001: two's-complement, wrap modulo 2^WORD_SIZE, no overflow flag.
  - MLT=00010: signed shift-add on operand magnitudes, sign applied at the end; result is the low WORD_SIZE bits of the product.
  - DIV=00011: signed restoring divide on magnitudes; quotient truncates toward zero. b=0: single-cycle, result all ones, div_zero=1. Most-negative / -1: result = most-negative.
  - NOT=00100: ~a. AND=00101, OR=00110, XOR=00111: bitwise.
  - Shifts use b_in[SHAMT_BITS-1:0]. SUL=01000 and SSL=01001: logical left. SUR=01010: logical right. SSR=01011: arithmetic right.
  - EQ=10000, NEQ=10001, LT=10010, LEQ=10011: signed compares; result is 0 or 1, zero-extended.
  - BYTESEL=11101: byte k = b_in mod (WORD_SIZE/8); byte 0 is the most significant byte; result = that byte, zero-extended.
  - BYTECLR=11110: a with byte k cleared to 0.
  - Any other code: result 0, illegal=1, single-cycle.
- div_zero and illegal update only on done, and are cleared by the next done that does not set them.

Optional Feature:
- Macro NIU_ALU_FAST_MUL_EN.
- When defined: MLT is single-cycle (combinational multiply, low WORD_SIZE bits, registered at E0) and the MUL state is not built.
- When undefined: MLT is the iterative WORD_SIZE-cycle multiply described above.
- All other behaviour is identical in both builds.

Test Plan:
- ADD a=7, b=-3 → result=4 and done=1 in the cycle after E0, busy never high; back-to-back SUB 4-9 on the next edge → result=0xFFFFFFFB.
- MLT a=-6, b=7 → busy high 32 cycles, result=0xFFFFFFD6 with done after edge E0+32; a start of ADD at cycle 10 is ignored, i.e. no extra done (fast build: done at E0).
- DIV a=-7, b=2 → result=0xFFFFFFFD, div_zero=0 after 32 cycles; then DIV 5/0 → result=0xFFFFFFFF, div_zero=1, latency 1.
- a=0x12345678: BYTESEL b=1 → 0x34; BYTECLR b=3 → 0x12345600; b=4 wraps to byte 0, so BYTESEL → 0x12; SSR a=0x80000000 by 4 → 0xF8000000.
- LT a=-1, b=1 → 1; LEQ a=b=5 → 1; func=10100 → result=0, illegal=1; next ADD clears illegal.
- Drive reset=0 at cycle 10 of a DIV → busy, done, result and flags go to 0 immediately (before the next edge); after release, ADD 1+1 → 2 with normal latency.
